shift_reg_universal: RTL and testbench
======================================

# shift_reg_universal

Parametrised universal register: a WIDTH-bit bank of synchronous D flip-flops with preset, clear, hold, shift-left, shift-right and parallel-load modes. It also tracks how many bits have been shifted out since the last load. It is the multi-bit successor of the single-bit preset/clear D flip-flop and is used as a serialiser/deserialiser and general storage register in the datapath. True and complemented outputs are provided, as on the single-bit cell.

## Interface
- WIDTH, default 8: register width in bits; legal range 2–64.
- CNT_W, default $clog2(WIDTH+1): width of the shift counter; derived, not overridden.
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset, highest priority; clears register and counter.
- pre  input  1  synchronous active-high preset; sets all register bits to 1 and clears the counter.
- en  input  1  mode enable; when low, register and counter hold.
- mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- d  input  WIDTH  parallel load data.
- si_l  input  1  serial input entering bit 0 on a left shift.
- si_r  input  1  serial input entering bit WIDTH-1 on a right shift.
- rot  input  1  rotate select; present only with USR_ROTATE_EN.
- q  output  WIDTH  register contents.
- qn  output  WIDTH  bitwise complement of q.
- so_l  output  1  q[WIDTH-1]: the bit that leaves on the next left shift.
- so_r  output  1  q[0]: the bit that leaves on the next right shift.
- cnt  output  CNT_W  number of shifts since the last load, preset or clear; saturates at WIDTH.
- drained  output  1  high when cnt == WIDTH.

## Operation
- Priority per rising clk edge: clr > pre > en.
  - clr=1: q=0, cnt=0.
  - pre=1 and clr=0: q = all ones, cnt=0.
  - Otherwise, with en=1, mode applies as below.
  - With en=0, everything holds.
- mode 00 (hold): q and cnt unchanged.
- mode 01 (shift left): q = {q[WIDTH-2:0], si_l}; cnt = min(cnt+1, WIDTH).
- mode 10 (shift right): q = {si_r, q[WIDTH-1:1]}; cnt = min(cnt+1, WIDTH).
- mode 11 (parallel load): q = d; cnt = 0.
- Counter behaviour:
  - The counter saturates: shifting with cnt == WIDTH keeps cnt at WIDTH and still shifts the data.
  - Mixing left and right shifts still increments cnt; it counts shift operations, not net displacement.
- Output derivation:
  - qn, so_l, so_r and drained are combinational from the state registers.
  - qn = ~q at all times.

## Timing
- Reset state (after any edge with clr=1):
  - q = 0, qn = all ones.
  - so_l = 0, so_r = 0.
  - cnt = 0, drained = 0.
- Latency: one cycle. The edge that samples a command updates q/cnt, and the outputs are valid immediately after that edge.
- Holding clr high for multiple cycles holds the reset state; it is released on the first edge with clr=0.
- clr asserted in the middle of a shift sequence aborts it on that edge. Any simultaneous pre, en or mode is ignored.
- pre and a load in the same cycle: pre wins, q = all ones.
- Serial inputs are sampled only on edges that perform a shift of the matching direction.
- A load of d while drained=1 clears drained on the next edge.

## Configuration
- USR_ROTATE_EN defined:
  - The rot port exists.
  - With rot=1 during a shift, the serial input is replaced by the exiting bit:
    - Left shift: q = {q[WIDTH-2:0], q[WIDTH-1]}.
    - Right shift: q = {q[0], q[WIDTH-1:1]}.
  - cnt still increments and saturates as in a normal shift.
  - rot is ignored in every non-shift mode.
- USR_ROTATE_EN undefined:
  - No rot port.
  - Shifts always take si_l/si_r.

## Test plan
- Reset: WIDTH=8, clr=1 with pre=1, en=1, mode=11, d=8'hA5 -> q=8'h00, qn=8'hFF, cnt=0, drained=0.
- Load then shift-left out: load 8'hB4, then 8 left shifts with si_l=0 -> so_l sequence before each edge is 1,0,1,1,0,1,0,0; q=8'h00; cnt=8; drained=1. A 9th shift keeps cnt=8.
- Shift right in: after clr, 8 right shifts with si_r pattern 1,1,0,1,0,0,1,0 -> q=8'h4B, cnt=8.
- Enable and priority:
  - en=0 with mode=01 -> q unchanged, cnt unchanged.
  - pre=1 with mode=11, d=8'h00 -> q=8'hFF, cnt=0.
  - Then clr=1 and pre=1 together -> q=8'h00.
- Mid-operation reset: load 8'hF0, 3 left shifts (cnt=3), then clr on the 4th edge -> q=8'h00, cnt=0.
- Rotate (USR_ROTATE_EN): load 8'h81, rot=1, one left shift -> q=8'h03; one right shift -> q=8'h81; cnt=2.

Source files
------------

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: clear, preset, hold, shift left/right, parallel load,
// plus a saturating shift counter. Define USR_ROTATE_EN to add the rot port for rotating shifts.
module shift_reg_universal #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_l,
    input  logic             si_r,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             so_l,
    output logic             so_r,
    output logic [CNT_W-1:0] cnt,
    output logic             drained
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHL   = 2'b01;
    localparam logic [1:0] MODE_SHR   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic             fill_l;
    logic             fill_r;
    logic [CNT_W-1:0] cnt_inc;

    // With rotation, the bit leaving one end re-enters at the other instead of the serial input.
`ifdef USR_ROTATE_EN
    assign fill_l = rot ? q[WIDTH-1] : si_l;
    assign fill_r = rot ? q[0]       : si_r;
`else
    assign fill_l = si_l;
    assign fill_r = si_r;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (pre) begin
            q   <= '1;
            cnt <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    q   <= {q[WIDTH-2:0], fill_l};
                    cnt <= cnt_inc;
                end
                MODE_SHR: begin
                    q   <= {fill_r, q[WIDTH-1:1]};
                    cnt <= cnt_inc;
                end
                MODE_LOAD: begin
                    q   <= d;
                    cnt <= '0;
                end
                MODE_HOLD: begin
                    q   <= q;
                    cnt <= cnt;
                end
                default: begin
                    q   <= q;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign qn      = ~q;
    assign so_l    = q[WIDTH-1];
    assign so_r    = q[0];
    assign drained = (cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed-vector bench for shift_reg_universal at WIDTH=8; rotate vectors run only
// when USR_ROTATE_EN is defined.
module tb_shift_reg_universal;

    localparam int W = 8;

    typedef struct {
        logic       clr;
        logic       pre;
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sl;
        logic       sr;
        logic       rt;
        logic [7:0] eq;
        logic [3:0] ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       pre = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       si_l = 1'b0;
    logic       si_r = 1'b0;
    logic       rot = 1'b0;
    logic [7:0] q;
    logic [7:0] qn;
    logic       so_l;
    logic       so_r;
    logic [3:0] cnt;
    logic       drained;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_reg_universal #(.WIDTH(W)) dut (
        .clk(clk),
        .clr(clr),
        .pre(pre),
        .en(en),
        .mode(mode),
        .d(d),
        .si_l(si_l),
        .si_r(si_r),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .q(q),
        .qn(qn),
        .so_l(so_l),
        .so_r(so_r),
        .cnt(cnt),
        .drained(drained)
    );

    function automatic vec_t mk(input logic c, input logic p, input logic e, input logic [1:0] m,
                                input logic [7:0] dd, input logic l, input logic r, input logic rt,
                                input logic [7:0] eq, input logic [3:0] ec);
        vec_t v;
        v.clr = c; v.pre = p; v.en = e; v.mode = m; v.d = dd;
        v.sl = l; v.sr = r; v.rt = rt; v.eq = eq; v.ec = ec;
        return v;
    endfunction

    task automatic apply(input string name, input vec_t v);
        logic [7:0] xq;
        @(negedge clk);
        clr = v.clr; pre = v.pre; en = v.en; mode = v.mode;
        d = v.d; si_l = v.sl; si_r = v.sr; rot = v.rt;
        @(posedge clk);
        #1;
        xq = v.eq;
        n_vec++;
        if (q !== xq || qn !== ~xq || so_l !== xq[7] || so_r !== xq[0] ||
            cnt !== v.ec || drained !== (v.ec == 4'd8)) begin
            n_err++;
            $display("FAIL %s: got q=%h qn=%h so_l=%b so_r=%b cnt=%0d drained=%b, expected q=%h qn=%h so_l=%b so_r=%b cnt=%0d drained=%b",
                     name, q, qn, so_l, so_r, cnt, drained,
                     xq, ~xq, xq[7], xq[0], v.ec, (v.ec == 4'd8));
        end
    endtask

    vec_t tbl[28];

    initial begin
        // reset with everything else asserted
        tbl[0]  = mk(1,1,1,2'b11,8'hA5,0,0,0, 8'h00,0);
        tbl[1]  = mk(0,0,1,2'b11,8'hB4,0,0,0, 8'hB4,0);
        // shift 0xB4 out to the left
        tbl[2]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h68,1);
        tbl[3]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'hD0,2);
        tbl[4]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'hA0,3);
        tbl[5]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h40,4);
        tbl[6]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h80,5);
        tbl[7]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h00,6);
        tbl[8]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h00,7);
        tbl[9]  = mk(0,0,1,2'b01,8'h00,0,1,0, 8'h00,8);
        tbl[10] = mk(0,0,1,2'b01,8'h00,1,0,0, 8'h01,8);
        tbl[11] = mk(1,0,0,2'b00,8'h00,0,0,0, 8'h00,0);
        // shift in 1,1,0,1,0,0,1,0 from the right
        tbl[12] = mk(0,0,1,2'b10,8'h00,0,1,0, 8'h80,1);
        tbl[13] = mk(0,0,1,2'b10,8'h00,0,1,0, 8'hC0,2);
        tbl[14] = mk(0,0,1,2'b10,8'h00,1,0,0, 8'h60,3);
        tbl[15] = mk(0,0,1,2'b10,8'h00,0,1,0, 8'hB0,4);
        tbl[16] = mk(0,0,1,2'b10,8'h00,1,0,0, 8'h58,5);
        tbl[17] = mk(0,0,1,2'b10,8'h00,0,0,0, 8'h2C,6);
        tbl[18] = mk(0,0,1,2'b10,8'h00,0,1,0, 8'h96,7);
        tbl[19] = mk(0,0,1,2'b10,8'h00,1,0,0, 8'h4B,8);
        tbl[20] = mk(0,0,0,2'b01,8'hFF,1,1,0, 8'h4B,8);
        tbl[21] = mk(0,0,1,2'b11,8'h3C,0,0,0, 8'h3C,0);
        tbl[22] = mk(0,1,1,2'b11,8'h00,0,0,0, 8'hFF,0);
        tbl[23] = mk(1,1,1,2'b11,8'h00,0,0,0, 8'h00,0);
        tbl[24] = mk(0,0,1,2'b11,8'h5A,0,0,0, 8'h5A,0);
        tbl[25] = mk(0,0,1,2'b01,8'h00,1,0,0, 8'hB5,1);
        tbl[26] = mk(0,0,1,2'b00,8'hFF,0,1,0, 8'hB5,1);
        tbl[27] = mk(0,0,1,2'b10,8'h00,1,0,0, 8'h5A,2);

        for (int i = 0; i < 28; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // clear aborts a shift sequence in progress
        apply("mid_load",  mk(0,0,1,2'b11,8'hF0,0,0,0, 8'hF0,0));
        apply("mid_shl1",  mk(0,0,1,2'b01,8'h00,0,0,0, 8'hE0,1));
        apply("mid_shl2",  mk(0,0,1,2'b01,8'h00,0,0,0, 8'hC0,2));
        apply("mid_shl3",  mk(0,0,1,2'b01,8'h00,0,0,0, 8'h80,3));
        apply("mid_clr",   mk(1,1,1,2'b01,8'h00,1,1,0, 8'h00,0));
        // clear held for several cycles, released on first edge without it
        apply("clr_hold1", mk(1,0,1,2'b01,8'h00,1,1,0, 8'h00,0));
        apply("clr_hold2", mk(1,0,1,2'b11,8'hAA,1,1,0, 8'h00,0));
        apply("clr_rel",   mk(0,0,1,2'b01,8'h00,1,0,0, 8'h01,1));

`ifdef USR_ROTATE_EN
        apply("rot_load",  mk(0,0,1,2'b11,8'h81,0,0,1, 8'h81,0));
        apply("rot_left",  mk(0,0,1,2'b01,8'h00,0,0,1, 8'h03,1));
        apply("rot_right", mk(0,0,1,2'b10,8'h00,0,0,1, 8'h81,2));
        apply("rot_hold",  mk(0,0,1,2'b00,8'h00,1,1,1, 8'h81,2));
        apply("rot_off",   mk(0,0,1,2'b01,8'h00,0,0,0, 8'h02,3));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
